// File: rtl/ld_st_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : ld_st_issue_queue
// Brief    : In-order load/store issue queue with CDB operand snooping.
// Revision : 1.0 - initial release
// ============================================================================
module ld_st_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int IMM_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic                     disp_ld_st_opcode,
    input  logic [TAG_W-1:0]         disp_rs1_tag,
    input  logic                     disp_rs1_data_valid,
    input  logic [31:0]              disp_rs1_data,
    input  logic [TAG_W-1:0]         disp_rs2_tag,
    input  logic                     disp_rs2_data_valid,
    input  logic [31:0]              disp_rs2_data,
    input  logic [IMM_W-1:0]         disp_immediate,
    input  logic [TAG_W-1:0]         disp_rd_tag,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_result,
    output logic                     issue_req,
    input  logic                     issue_granted,
    output logic                     issue_ld_st_opcode,
    output logic [31:0]              issue_rs1_data,
    output logic [31:0]              issue_rs2_data,
    output logic [IMM_W-1:0]         issue_immediate,
    output logic [TAG_W-1:0]         issue_rd_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

    logic             r_valid    [DEPTH];
    logic             r_op       [DEPTH];
    logic [TAG_W-1:0] r_rs1_tag  [DEPTH];
    logic             r_rs1_rdy  [DEPTH];
    logic [31:0]      r_rs1_data [DEPTH];
    logic [TAG_W-1:0] r_rs2_tag  [DEPTH];
    logic             r_rs2_rdy  [DEPTH];
    logic [31:0]      r_rs2_data [DEPTH];
    logic [IMM_W-1:0] r_imm      [DEPTH];
    logic [TAG_W-1:0] r_rd_tag   [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_disp_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_issue_req;
    logic        w_disp_rs1_rdy;
    logic        w_disp_rs2_rdy;
    logic [31:0] w_disp_rs1_data;
    logic [31:0] w_disp_rs2_data;

    // Ready depends only on occupancy, so a full queue never accepts even when popping.
    assign w_disp_ready = (r_count != c_full_count);
    assign w_push       = disp_valid & w_disp_ready;
    assign w_issue_req  = r_valid[r_rd_ptr] & r_rs1_rdy[r_rd_ptr] &
                          (~r_op[r_rd_ptr] | r_rs2_rdy[r_rd_ptr]);
    assign w_pop        = w_issue_req & issue_granted;

    // Catch a broadcast of the producer tag arriving in the dispatch cycle itself.
    always_comb begin
        w_disp_rs1_rdy  = disp_rs1_data_valid;
        w_disp_rs1_data = disp_rs1_data;
        w_disp_rs2_rdy  = disp_rs2_data_valid;
        w_disp_rs2_data = disp_rs2_data;
        if (!disp_rs1_data_valid && cdb_valid && (cdb_tag == disp_rs1_tag)) begin
            w_disp_rs1_rdy  = 1'b1;
            w_disp_rs1_data = cdb_result;
        end
        if (!disp_rs2_data_valid && cdb_valid && (cdb_tag == disp_rs2_tag)) begin
            w_disp_rs2_rdy  = 1'b1;
            w_disp_rs2_data = cdb_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]    <= 1'b0;
                r_op[i]       <= 1'b0;
                r_rs1_tag[i]  <= '0;
                r_rs1_rdy[i]  <= 1'b0;
                r_rs1_data[i] <= '0;
                r_rs2_tag[i]  <= '0;
                r_rs2_rdy[i]  <= 1'b0;
                r_rs2_data[i] <= '0;
                r_imm[i]      <= '0;
                r_rd_tag[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_op[i]       <= disp_ld_st_opcode;
                    r_rs1_tag[i]  <= disp_rs1_tag;
                    r_rs1_rdy[i]  <= w_disp_rs1_rdy;
                    r_rs1_data[i] <= w_disp_rs1_data;
                    r_rs2_tag[i]  <= disp_rs2_tag;
                    r_rs2_rdy[i]  <= w_disp_rs2_rdy;
                    r_rs2_data[i] <= w_disp_rs2_data;
                    r_imm[i]      <= disp_immediate;
                    r_rd_tag[i]   <= disp_rd_tag;
                end else begin
                    if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (r_valid[i] && !r_rs1_rdy[i] && cdb_valid && (cdb_tag == r_rs1_tag[i])) begin
                        r_rs1_rdy[i]  <= 1'b1;
                        r_rs1_data[i] <= cdb_result;
                    end
                    if (r_valid[i] && !r_rs2_rdy[i] && cdb_valid && (cdb_tag == r_rs2_tag[i])) begin
                        r_rs2_rdy[i]  <= 1'b1;
                        r_rs2_data[i] <= cdb_result;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign disp_ready         = w_disp_ready;
    assign count              = r_count;
    assign issue_req          = w_issue_req;
    assign issue_ld_st_opcode = w_issue_req & r_op[r_rd_ptr];
    assign issue_rs1_data     = w_issue_req ? r_rs1_data[r_rd_ptr] : 32'd0;
    assign issue_rs2_data     = (w_issue_req && r_op[r_rd_ptr]) ? r_rs2_data[r_rd_ptr] : 32'd0;
    assign issue_immediate    = w_issue_req ? r_imm[r_rd_ptr] : '0;
    assign issue_rd_tag       = w_issue_req ? r_rd_tag[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: doc/ld_st_issue_queue.md
Name: ld_st_issue_queue

Overview:
- In-order load/store issue queue between dispatch and the memory execution unit.
- Buffers up to DEPTH memory ops and snoops the CDB to capture pending rs1/rs2 operands.
- Presents the head entry to the memory execution unit once its operands are ready; pops it on issue grant.
- Issue is strictly in program order; no load/store reordering.

Parameters:
DEPTH, 4, number of queue entries (power of 2, >=2)
TAG_W, 6, ROB/physical tag width
IMM_W, 32, sign-extended immediate width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous flush (branch mispredict); empties queue
disp_valid  input  1  dispatch request
disp_ready  output  1  queue can accept this cycle (= ~full)
disp_ld_st_opcode  input  1  0 = load, 1 = store
disp_rs1_tag  input  TAG_W  producer tag of rs1
disp_rs1_data_valid  input  1  rs1 data already available
disp_rs1_data  input  32  rs1 value (meaningful if valid)
disp_rs2_tag  input  TAG_W  producer tag of rs2 (stores only)
disp_rs2_data_valid  input  1  rs2 data available (loads: driven 1)
disp_rs2_data  input  32  rs2 value
disp_immediate  input  IMM_W  offset
disp_rd_tag  input  TAG_W  destination tag
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB tag
cdb_result  input  32  CDB data
issue_req  output  1  head entry valid and operands ready
issue_granted  input  1  memory unit accepts head this cycle
issue_ld_st_opcode  output  1  head opcode
issue_rs1_data  output  32  head rs1
issue_rs2_data  output  32  head rs2
issue_immediate  output  IMM_W  head immediate
issue_rd_tag  output  TAG_W  head rd tag
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer; wr_ptr, rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count register 0..DEPTH.
- Reset (async, rst=1): all entry valid bits, pointers and count = 0. Outputs: issue_req=0, all issue_* = 0, disp_ready=1, count=0.
- Dispatch: push when disp_valid & disp_ready at posedge.
  - disp_ready = (count != DEPTH), purely from count; no push-while-full even if a pop occurs the same cycle.
- Dispatch bypass: if cdb_valid and cdb_tag matches a non-ready dispatched operand in the same cycle, store cdb_result and mark that operand ready.
- CDB snoop: every cycle, each valid entry with a non-ready operand whose tag == cdb_tag (with cdb_valid) captures cdb_result and sets that operand ready. rs1 and rs2 may both match the same broadcast.
- Issue readiness:
  - issue_req = head valid & rs1_ready & (opcode==0 | rs2_ready).
  - Combinational from head registers only; no CDB-to-issue bypass in the same cycle.
- issue_* outputs:
  - Driven combinationally from head entry when issue_req=1; otherwise 0.
  - issue_rs2_data is 0 for loads.
- Pop: when issue_req & issue_granted at posedge; head cleared, rd_ptr+1. issue_granted while issue_req=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Zero-latency path: a push into an empty queue is visible as head the next cycle; issue_req may assert that cycle if operands are ready.
- Flush: synchronous, has priority over push, pop and snoop. Next cycle: count=0, pointers=0, all valid bits=0, issue_req=0.
- Reset asserted mid-operation discards all entries immediately, regardless of grant.
- Count: increments on push-only, decrements on pop-only; never exceeds DEPTH or underflows.

Test Plan:
1. Reset, then dispatch load (rs1 ready, data 0x1001_0000, imm 8, rd_tag 5) -> next cycle issue_req=1, issue_rs1_data=0x1001_0000, issue_immediate=8; grant -> count 1->0, issue_req=0.
2. Dispatch store with rs2 pending (tag 12); CDB (tag 12, 0xDEADBEEF) two cycles later -> issue_req stays 0 until the cycle after the broadcast, then issue_rs2_data=0xDEADBEEF.
3. Dispatch 4 ops without grant -> count=4, disp_ready=0; 5th disp_valid is not accepted. Grant once -> disp_ready=1 next cycle; wrap-around push lands at slot 0 and issues in order.
4. Head load waiting on tag 3, second entry ready -> issue_req stays 0 (in-order). CDB tag 3 -> head issues, then second entry.
5. Dispatch with rs1 tag 7 in the same cycle as CDB tag 7 (0x55) -> entry captured ready; issue_rs1_data=0x55 next cycle.
6. 3 entries queued, flush coincident with push and grant -> next cycle count=0, issue_req=0, disp_ready=1. Repeat with async rst mid-cycle -> outputs zero immediately.
